// File: rtl/sbp_result_fifo.sv
// Credit-managed result FIFO behind the lookup stage pipeline; optional counters under SBP_RESULT_STATS_EN.
// Latency: a pushed entry reaches the head one cycle after in_valid_i (no fall-through).
// Backpressure: ingress launches only while issue_ready_o is high; when full without a pop, the result is dropped and overflow_o is set.
module sbp_result_fifo #(
   parameter int DEPTH       = 16,
   parameter int RESULT_BITS = 17
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     issue_i,
   output logic                     issue_ready_o,
   input  logic                     in_valid_i,
   input  logic [31:0]              in_ip_addr_i,
   input  logic [RESULT_BITS-1:0]   in_result_i,
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic [31:0]              out_ip_addr_o,
   output logic [RESULT_BITS-1:0]   out_result_o,
   output logic [$clog2(DEPTH):0]   level_o,
`ifdef SBP_RESULT_STATS_EN
   output logic [31:0]              lookups_o,
   output logic [31:0]              stall_cycles_o,
`endif
   output logic                     overflow_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef struct packed {
      logic [31:0]            ip_addr;
      logic [RESULT_BITS-1:0] result;
   } entry_t;

   entry_t        mem [DEPTH];
   entry_t        head;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [LW-1:0] level;
   logic [LW-1:0] inflight;
   logic [LW:0]   committed;
   logic          overflow;
   logic          full;
   logic          issue_acc;
   logic          issue_err;
   logic          push;
   logic          pop;
   logic          drop;

   // Credits count both stored entries and lookups still travelling through the stages.
   always_comb begin
      committed     = {1'b0, level} + {1'b0, inflight};
      issue_ready_o = committed < (LW+1)'(DEPTH);
      full          = level == LW'(DEPTH);
      out_valid_o   = level != '0;
      issue_acc     = issue_i & issue_ready_o;
      issue_err     = issue_i & ~issue_ready_o;
      pop           = out_valid_o & out_ready_i;
      push          = in_valid_i & (~full | pop);
      drop          = in_valid_i & full & ~pop;
   end

   always_comb begin
      head          = mem[rd_ptr];
      out_ip_addr_o = head.ip_addr;
      out_result_o  = head.result;
      level_o       = level;
      overflow_o    = overflow;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         inflight <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
         // A return with nothing outstanding is tolerated rather than wrapping the counter.
         if (issue_acc && !in_valid_i)
            inflight <= inflight + 1'b1;
         else if (!issue_acc && in_valid_i && inflight != '0)
            inflight <= inflight - 1'b1;
         if (issue_err || drop) overflow <= 1'b1;
      end
   end

   // Storage is not reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {in_ip_addr_i, in_result_i};
   end

`ifdef SBP_RESULT_STATS_EN
   logic [31:0] lookups_q;
   logic [31:0] stall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         lookups_q <= '0;
         stall_q   <= '0;
      end else begin
         if (pop)                         lookups_q <= lookups_q + 32'd1;
         if (out_valid_o && !out_ready_i) stall_q   <= stall_q + 32'd1;
      end
   end

   assign lookups_o      = lookups_q;
   assign stall_cycles_o = stall_q;
`endif

endmodule
